rgbw_spi_frame_sender: RTL and testbench

- SPI master (mode 0, MSB first) that serialises one 7-byte RGBW control frame to the lamp controller's SPI slave input (sck/cs/mosi).
- Byte order on the wire: lint, red, green, blue, color_idx, white, mode.
- Sits on the host/test side: the bench driver, and the bridge for chaining a second lamp controller.

---
 rtl/rgbw_spi_pkg.sv | 18 +
 rtl/spi_byte_shifter.sv | 49 ++++
 rtl/rgbw_spi_frame_sender.sv | 121 ++++++++++++
 tb/tb_rgbw_spi_frame_sender.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/rgbw_spi_pkg.sv
// rgbw_spi_pkg: frame layout, SPI mode and FSM encoding shared by the RGBW frame sender
package rgbw_spi_pkg;
  localparam int FRAME_BYTES = 7;
  localparam logic [2:0] IDX_LINT      = 3'd0;
  localparam logic [2:0] IDX_RED       = 3'd1;
  localparam logic [2:0] IDX_GREEN     = 3'd2;
  localparam logic [2:0] IDX_BLUE      = 3'd3;
  localparam logic [2:0] IDX_COLOR_IDX = 3'd4;
  localparam logic [2:0] IDX_WHITE     = 3'd5;
  localparam logic [2:0] IDX_MODE      = 3'd6;
  localparam logic CPOL = 1'b0;
  localparam logic CPHA = 1'b0;
  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, GAP, HOLD, TURN} state_t;
  // down-counter reload value for an n-cycle interval (zero-length intervals are skipped by the FSM)
  function automatic logic [15:0] span(input int unsigned n);
    return n == 0 ? 16'd0 : 16'(n - 1);
  endfunction
endpackage

// File: rtl/spi_byte_shifter.sv
// spi_byte_shifter: shifts one byte MSB first as mode-0 sck/mosi with SCK_HALF-cycle half periods
module spi_byte_shifter
  import rgbw_spi_pkg::*;
#(
  parameter int unsigned SCK_HALF = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       run,
  input  logic [7:0] data,
  output logic       sck,
  output logic       mosi,
  output logic       byte_done
);
  localparam logic [7:0] HALF_M1 = 8'(SCK_HALF - 1);
  logic [7:0] sr;
  logic [7:0] hcnt;
  logic [2:0] bcnt;
  logic       active;
  assign mosi = sr[7];
  assign byte_done = active && sck && hcnt == 8'd0 && bcnt == 3'd0;
  // load presents bit7 on mosi at once; run additionally starts clocking the byte out
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sr     <= '0;
      hcnt   <= '0;
      bcnt   <= '0;
      sck    <= CPOL;
      active <= 1'b0;
    end else if (load) begin
      sr     <= data;
      hcnt   <= HALF_M1;
      bcnt   <= 3'd7;
      sck    <= CPOL;
      active <= run;
    end else if (active) begin
      if (hcnt != 8'd0) hcnt <= hcnt - 8'd1;
      else begin
        hcnt <= HALF_M1;
        sck  <= ~sck;
        if (sck) begin
          if (bcnt == 3'd0) active <= 1'b0;
          else sr <= {sr[6:0], 1'b0};
          bcnt <= bcnt - 3'd1;
        end
      end
    end
endmodule

// File: rtl/rgbw_spi_frame_sender.sv
// rgbw_spi_frame_sender: sends one 7-byte RGBW control frame as an SPI mode-0 master
module rgbw_spi_frame_sender
  import rgbw_spi_pkg::*;
#(
  parameter int unsigned SCK_HALF = 4,
  parameter int unsigned CS_LEAD  = 1,
  parameter int unsigned BYTE_GAP = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] lint_in,
  input  logic [7:0] red_in,
  input  logic [7:0] green_in,
  input  logic [7:0] blue_in,
  input  logic [7:0] color_idx_in,
  input  logic [7:0] white_in,
  input  logic [7:0] mode_in,
  output logic       sck,
  output logic       mosi,
  output logic       cs,
  output logic       busy,
  output logic       done
);
  localparam int unsigned LEAD_LEN = CS_LEAD * SCK_HALF;
  localparam int unsigned GAP_LEN  = BYTE_GAP * SCK_HALF;
  state_t                        state, state_d;
  logic [FRAME_BYTES-1:0][7:0]   frame;
  logic [2:0]                    idx, idx_d, idx_inc;
  logic [15:0]                   dcnt, dcnt_d;
  logic                          cs_d, busy_d, done_d, snap, ld, run, byte_done;
  logic [7:0]                    ld_data;
  assign idx_inc = idx + 3'd1;
  spi_byte_shifter #(.SCK_HALF(SCK_HALF)) u_shifter (
    .clk(clk),
    .rst_n(rst_n),
    .load(ld),
    .run(run),
    .data(ld_data),
    .sck(sck),
    .mosi(mosi),
    .byte_done(byte_done)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      frame <= '0;
      idx   <= '0;
      dcnt  <= '0;
      cs    <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
      dcnt  <= dcnt_d;
      cs    <= cs_d;
      busy  <= busy_d;
      done  <= done_d;
      if (snap) frame <= {mode_in, white_in, color_idx_in, blue_in, green_in, red_in, lint_in};
    end
  // the shifter is reloaded with the current byte at the end of LEAD/GAP to start clocking it
  always_comb begin
    state_d = state;
    idx_d   = idx;
    dcnt_d  = dcnt;
    cs_d    = cs;
    busy_d  = busy;
    done_d  = 1'b0;
    snap    = 1'b0;
    ld      = 1'b0;
    run     = 1'b0;
    ld_data = frame[idx];
    case (state)
      IDLE: if (start) begin
        snap    = 1'b1;
        ld      = 1'b1;
        ld_data = lint_in;
        run     = LEAD_LEN == 0;
        state_d = LEAD_LEN == 0 ? SHIFT : LEAD;
        idx_d   = IDX_LINT;
        dcnt_d  = span(LEAD_LEN);
        cs_d    = 1'b0;
        busy_d  = 1'b1;
      end
      LEAD, GAP: if (dcnt == 16'd0) begin
        ld      = 1'b1;
        run     = 1'b1;
        state_d = SHIFT;
      end else dcnt_d = dcnt - 16'd1;
      SHIFT: if (byte_done) begin
        if (idx == IDX_MODE) begin
          state_d = HOLD;
          dcnt_d  = span(SCK_HALF);
        end else begin
          ld      = 1'b1;
          ld_data = frame[idx_inc];
          run     = GAP_LEN == 0;
          state_d = GAP_LEN == 0 ? SHIFT : GAP;
          idx_d   = idx_inc;
          dcnt_d  = span(GAP_LEN);
        end
      end
      HOLD: if (dcnt == 16'd0) begin
        ld      = 1'b1;
        ld_data = 8'h00;
        cs_d    = 1'b1;
        state_d = TURN;
        dcnt_d  = span(2 * SCK_HALF);
      end else dcnt_d = dcnt - 16'd1;
      TURN: if (dcnt == 16'd0) begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end else begin
        dcnt_d = dcnt - 16'd1;
        done_d = dcnt == 16'd1;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_rgbw_spi_frame_sender.sv
// tb_rgbw_spi_frame_sender: drives frames into two sender instances and recovers them with a slave model
module tb_rgbw_spi_frame_sender;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] start = 2'b00;
  logic [7:0] lint = 8'h00, red = 8'h00, green = 8'h00, blue = 8'h00, cidx = 8'h00, white = 8'h00, mode = 8'h00;
  logic [1:0] sck_w, mosi_w, cs_w, busy_w, done_w;
  logic [1:0] sck_q = 2'b00, cs_q = 2'b11;
  int checks = 0, errors = 0, cyc = 0;
  int rises[2], cs_low[2], dones[2], hi_run[2], done_hi[2], gap[2];
  int rise_cyc[2][128];
  bit rxb[2][128];

  always #5 clk = ~clk;

  rgbw_spi_frame_sender u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]),
    .lint_in(lint), .red_in(red), .green_in(green), .blue_in(blue),
    .color_idx_in(cidx), .white_in(white), .mode_in(mode),
    .sck(sck_w[0]), .mosi(mosi_w[0]), .cs(cs_w[0]), .busy(busy_w[0]), .done(done_w[0])
  );
  rgbw_spi_frame_sender #(.SCK_HALF(2), .CS_LEAD(1), .BYTE_GAP(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]),
    .lint_in(lint), .red_in(red), .green_in(green), .blue_in(blue),
    .color_idx_in(cidx), .white_in(white), .mode_in(mode),
    .sck(sck_w[1]), .mosi(mosi_w[1]), .cs(cs_w[1]), .busy(busy_w[1]), .done(done_w[1])
  );

  // slave model: samples mosi on each sck rise and measures cs/done timing
  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (sck_w[i] && !sck_q[i]) begin
        if (rises[i] < 128) begin
          rxb[i][rises[i]] = mosi_w[i];
          rise_cyc[i][rises[i]] = cyc;
        end
        rises[i]++;
      end
      if (!cs_w[i] && cs_q[i]) gap[i] = hi_run[i];
      if (!cs_w[i]) begin
        cs_low[i]++;
        hi_run[i] = 0;
      end else hi_run[i]++;
      if (done_w[i]) begin
        dones[i]++;
        done_hi[i] = hi_run[i];
      end
      sck_q[i] = sck_w[i];
      cs_q[i] = cs_w[i];
    end
  end

  typedef struct {
    int          inst;
    logic [55:0] bytes;
    int          cs_low;
    int          rises;
    int          done_hi;
    int          period;
    int          bgap;
  } vec_t;
  vec_t tv[5];

  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, got, exp);
    end
  endtask

  function automatic logic [7:0] rx_byte(input int i, input int k, input int base);
    logic [7:0] b;
    for (int j = 0; j < 8; j++) b[7-j] = rxb[i][base + 8*k + j];
    return b;
  endfunction

  task automatic mclr(input int i);
    rises[i] = 0;
    cs_low[i] = 0;
    dones[i] = 0;
    hi_run[i] = 0;
    done_hi[i] = 0;
    gap[i] = 0;
  endtask

  task automatic set_bytes(input logic [55:0] b);
    {lint, red, green, blue, cidx, white, mode} = b;
  endtask

  task automatic send(input int i, input logic [55:0] b);
    @(posedge clk);
    #1;
    mclr(i);
    set_bytes(b);
    start[i] = 1'b1;
    @(posedge clk);
    #1 start[i] = 1'b0;
  endtask

  task automatic wait_done(input int i);
    int k = 0;
    while (!done_w[i] && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 3000) chk("done_timeout", 0, 1);
  endtask

  initial begin
    tv[0] = '{0, 56'hFF12345607A502, 504, 56, 8, 8, 16};
    tv[1] = '{0, 56'h80010101010101, 504, 56, 8, 8, 16};
    tv[2] = '{0, 56'h00A53CC35AFF81, 504, 56, 8, 8, 16};
    tv[3] = '{1, 56'hFF12345607A502, 228, 56, 4, 4, 4};
    tv[4] = '{1, 56'hDEADBEEF0169C7, 228, 56, 4, 4, 4};
    mclr(0);
    mclr(1);
    repeat (2) @(negedge clk);
    chk("reset_cs", cs_w[0], 1);
    chk("reset_sck", sck_w[0], 0);
    chk("reset_mosi", mosi_w[0], 0);
    chk("reset_busy", busy_w[0], 0);
    chk("reset_done", done_w[0], 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      int i;
      i = tv[v].inst;
      send(i, tv[v].bytes);
      wait_done(i);
      repeat (3) @(negedge clk);
      for (int k = 0; k < 7; k++)
        chk($sformatf("v%0d_byte%0d", v, k), rx_byte(i, k, 0), tv[v].bytes[55-8*k -: 8]);
      chk($sformatf("v%0d_cs_low", v), cs_low[i], tv[v].cs_low);
      chk($sformatf("v%0d_rises", v), rises[i], tv[v].rises);
      chk($sformatf("v%0d_dones", v), dones[i], 1);
      chk($sformatf("v%0d_done_after_cs", v), done_hi[i], tv[v].done_hi);
      chk($sformatf("v%0d_busy_end", v), busy_w[i], 0);
      chk($sformatf("v%0d_sck_period", v), rise_cyc[i][1] - rise_cyc[i][0], tv[v].period);
      chk($sformatf("v%0d_byte_gap", v), rise_cyc[i][8] - rise_cyc[i][7], tv[v].bgap);
      if (v == 1) begin
        logic [63:0] got_m, exp_m;
        got_m = '0;
        exp_m = '0;
        for (int r = 1; r <= 56; r++) begin
          got_m[r] = rxb[0][r-1];
          exp_m[r] = (r == 1) || (r >= 16 && r % 8 == 0);
        end
        chk("bit_order", got_m, exp_m);
      end
    end

    begin
      int busy_low = 0;
      int k = 0;
      send(0, 56'hFF12345607A502);
      repeat (99) @(posedge clk);
      #1;
      red = 8'h00;
      start[0] = 1'b1;
      @(posedge clk);
      #1 start[0] = 1'b0;
      while (!done_w[0] && k < 3000) begin
        @(negedge clk);
        k++;
        if (!busy_w[0]) busy_low++;
      end
      repeat (60) @(negedge clk);
      chk("snap_red", rx_byte(0, 1, 0), 8'h12);
      chk("snap_dones", dones[0], 1);
      chk("snap_rises", rises[0], 56);
      chk("snap_cs_low", cs_low[0], 504);
      chk("snap_busy_low", busy_low, 0);
    end

    begin
      int k = 0;
      send(0, 56'h11223344556677 | 56'h000000FF000000);
      while (rises[0] < 29 && k < 3000) begin
        @(negedge clk);
        k++;
      end
      chk("rst_pre_sck", sck_w[0], 1);
      chk("rst_pre_mosi", mosi_w[0], 1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_cs", cs_w[0], 1);
      chk("rst_sck", sck_w[0], 0);
      chk("rst_mosi", mosi_w[0], 0);
      chk("rst_busy", busy_w[0], 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      send(0, 56'hFF12345607A502);
      wait_done(0);
      repeat (3) @(negedge clk);
      for (int b = 0; b < 7; b++)
        chk($sformatf("rst_fresh_byte%0d", b), rx_byte(0, b, 0), 8'({8'hFF, 8'h12, 8'h34, 8'h56, 8'h07, 8'hA5, 8'h02} >> (8*(6-b))));
      chk("rst_fresh_cs_low", cs_low[0], 504);
      chk("rst_fresh_rises", rises[0], 56);
    end

    begin
      send(0, 56'h0102030405060A);
      wait_done(0);
      @(posedge clk);
      #1;
      set_bytes(56'hF0E1D2C3B4A596);
      start[0] = 1'b1;
      @(posedge clk);
      #1 start[0] = 1'b0;
      @(negedge clk);
      wait_done(0);
      repeat (3) @(negedge clk);
      chk("b2b_dones", dones[0], 2);
      chk("b2b_rises", rises[0], 112);
      chk("b2b_cs_gap_min8", gap[0] >= 8, 1);
      chk("b2b_first_lint", rx_byte(0, 0, 0), 8'h01);
      chk("b2b_first_mode", rx_byte(0, 6, 0), 8'h0A);
      chk("b2b_second_lint", rx_byte(0, 0, 56), 8'hF0);
      chk("b2b_second_blue", rx_byte(0, 3, 56), 8'hC3);
      chk("b2b_second_mode", rx_byte(0, 6, 56), 8'h96);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
